// File: rtl/serial_deserializer_4bit_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding,
// frame line levels and a counter-width helper.
package serial_deserializer_4bit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

   // Line level that opens a frame (idle line is 0).
   localparam logic START_BIT = 1'b1;
   // Line level required to close a frame cleanly.
   localparam logic STOP_BIT  = 1'b0;

   // Counter width able to hold 0..w-1, never less than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_deserializer_4bit_sipo.sv
// Serial-in/parallel-out left shift register.
// Ports: clk, sync clear (i_clr), shift enable (i_en), serial bit (i_din),
// parallel word (o_q, newest bit in the LSB).
module shiftregister_sipo #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_din,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         if (WIDTH > 1) begin
            r_q <= {r_q[WIDTH-2:0], i_din};
         end else begin
            r_q <= WIDTH'(i_din);
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/serial_deserializer_4bit.sv
// Frame deserializer: start bit 1, WIDTH data bits MSB first, stop bit 0.
// Ports: clockpulse, notclear (sync active-low), serialInput, acknowledge,
// out/notout (held word and its inverse), dataValid, frameError, overrun.
module serial_deserializer_4bit
   import serial_deserializer_4bit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clockpulse,
   input  logic             notclear,
   input  logic             serialInput,
   input  logic             acknowledge,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] notout,
   output logic             dataValid,
   output logic             frameError,
   output logic             overrun
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_out;
   logic             r_dv;
   logic             r_fe;
   logic             r_ov;

   logic [WIDTH-1:0] w_shreg;
   logic             w_shift_en;
   logic             w_in_stop;
   logic             w_stop_ok;
   logic             w_load;
   logic             w_set_ov;
   logic             w_set_fe;

   assign w_shift_en = (r_state == ST_SHIFT);
   assign w_in_stop  = (r_state == ST_STOP);
   assign w_stop_ok  = w_in_stop && (serialInput == STOP_BIT);

   // A held word may be replaced only when it is free or being
   // acknowledged on this same edge.
   assign w_load   = w_stop_ok && (!r_dv || acknowledge);
   assign w_set_ov = w_stop_ok && r_dv && !acknowledge;
   assign w_set_fe = w_in_stop && (serialInput != STOP_BIT);

   shiftregister_sipo #(
      .WIDTH (WIDTH)
   ) u_sipo (
      .i_clk (clockpulse),
      .i_clr (!notclear),
      .i_en  (w_shift_en),
      .i_din (serialInput),
      .o_q   (w_shreg)
   );

   always_ff @(posedge clockpulse) begin
      if (!notclear) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_out   <= '0;
         r_dv    <= 1'b0;
         r_fe    <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (serialInput == START_BIT) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase

         // Load beats a same-edge acknowledge.
         if (w_load) begin
            r_out <= w_shreg;
            r_dv  <= 1'b1;
         end else if (acknowledge) begin
            r_dv  <= 1'b0;
         end

         // Setting a sticky flag beats a same-edge acknowledge.
         if (w_set_fe) begin
            r_fe <= 1'b1;
         end else if (acknowledge) begin
            r_fe <= 1'b0;
         end

         if (w_set_ov) begin
            r_ov <= 1'b1;
         end else if (acknowledge) begin
            r_ov <= 1'b0;
         end
      end
   end

   assign out        = r_out;
   assign notout     = ~r_out;
   assign dataValid  = r_dv;
   assign frameError = r_fe;
   assign overrun    = r_ov;

endmodule

// File: tb/tb_serial_deserializer_4bit.sv
// Randomised and directed bench for serial_deserializer_4bit with a
// frame-level reference model of the held word and flags.
module tb_serial_deserializer_4bit;

   logic       clockpulse;
   logic       notclear;
   logic       serialInput;
   logic       acknowledge;
   logic [3:0] out;
   logic [3:0] notout;
   logic       dataValid;
   logic       frameError;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] m_out;
   logic       m_dv;
   logic       m_fe;
   logic       m_ov;

   serial_deserializer_4bit #(
      .WIDTH (4)
   ) dut (
      .clockpulse  (clockpulse),
      .notclear    (notclear),
      .serialInput (serialInput),
      .acknowledge (acknowledge),
      .out         (out),
      .notout      (notout),
      .dataValid   (dataValid),
      .frameError  (frameError),
      .overrun     (overrun)
   );

   initial clockpulse = 1'b0;
   always #5 clockpulse = ~clockpulse;

   task automatic tick();
      @(posedge clockpulse);
      #1;
   endtask

   task automatic model_reset();
      m_out = 4'b0000;
      m_dv  = 1'b0;
      m_fe  = 1'b0;
      m_ov  = 1'b0;
   endtask

   // Whole-frame reference: what one frame does to the held word/flags.
   task automatic model_frame(input logic [3:0] d, input logic stopb,
                              input logic ack);
      logic good;
      good = (stopb == 1'b0);
      if (good && (!m_dv || ack)) begin
         m_out = d;
         m_dv  = 1'b1;
         if (ack) m_ov = 1'b0;
         if (ack) m_fe = 1'b0;
      end else if (good) begin
         m_ov = 1'b1;
      end else begin
         m_fe = 1'b1;
         if (ack) m_dv = 1'b0;
         if (ack) m_ov = 1'b0;
      end
   endtask

   task automatic model_ack();
      m_dv = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
   endtask

   // One idle cycle, start bit, data MSB first, stop bit (ack optional).
   task automatic drive_frame(input logic [3:0] d, input logic stopb,
                              input logic ack);
      serialInput = 1'b0;
      acknowledge = 1'b0;
      tick();
      serialInput = 1'b1;
      tick();
      for (int i = 3; i >= 0; i--) begin
         serialInput = d[i];
         tick();
      end
      serialInput = stopb;
      acknowledge = ack;
      tick();
      serialInput = 1'b0;
      acknowledge = 1'b0;
      model_frame(d, stopb, ack);
   endtask

   task automatic pulse_ack();
      acknowledge = 1'b1;
      tick();
      acknowledge = 1'b0;
      model_ack();
   endtask

   task automatic test_reset();
      notclear    = 1'b0;
      serialInput = 1'b1;
      acknowledge = 1'b1;
      tick();
      tick();
      model_reset();
      n_cmp++;
      if ({out, notout, dataValid, frameError, overrun} !== 11'b0000_1111_000) begin
         n_bad++;
         $display("FAIL reset: got out=%b notout=%b dv=%b fe=%b ov=%b want 0000 1111 0 0 0",
                  out, notout, dataValid, frameError, overrun);
      end
      notclear    = 1'b1;
      serialInput = 1'b0;
      acknowledge = 1'b0;
   endtask

   task automatic test_basic();
      logic [3:0] d;
      d = 4'b0011;
      repeat (3) tick();
      serialInput = 1'b1;
      tick();
      for (int i = 3; i >= 0; i--) begin
         serialInput = d[i];
         tick();
         n_cmp++;
         if (dataValid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early_dv bit%0d: got %b want 0", i, dataValid);
         end
      end
      serialInput = 1'b0;
      tick();
      model_frame(d, 1'b0, 1'b0);
      n_cmp++;
      if ({out, notout, dataValid, frameError, overrun} !==
          {m_out, ~m_out, m_dv, m_fe, m_ov} || out !== 4'b0011) begin
         n_bad++;
         $display("FAIL basic: got out=%b notout=%b dv=%b fe=%b ov=%b want out=0011 notout=1100 dv=1 fe=0 ov=0",
                  out, notout, dataValid, frameError, overrun);
      end
   endtask

   task automatic test_overrun();
      drive_frame(4'b1010, 1'b0, 1'b0);
      n_cmp++;
      if (out !== 4'b0011 || overrun !== 1'b1 || dataValid !== 1'b1 ||
          {out, m_ov} !== {m_out, 1'b1}) begin
         n_bad++;
         $display("FAIL overrun: got out=%b dv=%b ov=%b want out=0011 dv=1 ov=1",
                  out, dataValid, overrun);
      end
      pulse_ack();
      n_cmp++;
      if ({dataValid, overrun, frameError, out} !== {1'b0, 1'b0, 1'b0, 4'b0011}) begin
         n_bad++;
         $display("FAIL overrun_ack: got dv=%b ov=%b fe=%b out=%b want 0 0 0 0011",
                  dataValid, overrun, frameError, out);
      end
   endtask

   task automatic test_frame_error();
      drive_frame(4'b1111, 1'b1, 1'b0);
      n_cmp++;
      if ({frameError, dataValid, out} !== {1'b1, 1'b0, 4'b0011}) begin
         n_bad++;
         $display("FAIL frame_error: got fe=%b dv=%b out=%b want 1 0 0011",
                  frameError, dataValid, out);
      end
      drive_frame(4'b0110, 1'b0, 1'b0);
      n_cmp++;
      if ({out, dataValid, frameError} !== {4'b0110, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL after_frame_error: got out=%b dv=%b fe=%b want 0110 1 1",
                  out, dataValid, frameError);
      end
      pulse_ack();
      n_cmp++;
      if ({dataValid, frameError, overrun} !== 3'b000) begin
         n_bad++;
         $display("FAIL fe_ack: got dv=%b fe=%b ov=%b want 000",
                  dataValid, frameError, overrun);
      end
   endtask

   task automatic test_ack_at_stop();
      drive_frame(4'b0100, 1'b0, 1'b0);
      drive_frame(4'b1001, 1'b0, 1'b1);
      n_cmp++;
      if ({out, notout, dataValid, overrun} !== {4'b1001, 4'b0110, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL ack_at_stop: got out=%b notout=%b dv=%b ov=%b want 1001 0110 1 0",
                  out, notout, dataValid, overrun);
      end
      pulse_ack();
      pulse_ack();
      n_cmp++;
      if ({dataValid, out} !== {1'b0, 4'b1001}) begin
         n_bad++;
         $display("FAIL ack_idle: got dv=%b out=%b want 0 1001", dataValid, out);
      end
   endtask

   task automatic test_reset_mid();
      drive_frame(4'b1110, 1'b0, 1'b0);
      serialInput = 1'b0;
      tick();
      serialInput = 1'b1;
      tick();
      serialInput = 1'b1;
      tick();
      serialInput = 1'b0;
      tick();
      notclear = 1'b0;
      tick();
      notclear = 1'b1;
      model_reset();
      n_cmp++;
      if ({out, notout, dataValid, frameError, overrun} !== 11'b0000_1111_000) begin
         n_bad++;
         $display("FAIL reset_mid: got out=%b notout=%b dv=%b fe=%b ov=%b want 0000 1111 0 0 0",
                  out, notout, dataValid, frameError, overrun);
      end
      serialInput = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({dataValid, frameError, overrun} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_mid_discard: got dv=%b fe=%b ov=%b want 000",
                  dataValid, frameError, overrun);
      end
      drive_frame(4'b0101, 1'b0, 1'b0);
      n_cmp++;
      if ({out, dataValid} !== {4'b0101, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_mid_next: got out=%b dv=%b want 0101 1", out, dataValid);
      end
      pulse_ack();
   endtask

   task automatic test_data_ones();
      serialInput = 1'b0;
      tick();
      serialInput = 1'b1;
      tick();
      repeat (4) begin
         serialInput = 1'b1;
         tick();
      end
      n_cmp++;
      if (dataValid !== 1'b0) begin
         n_bad++;
         $display("FAIL ones_latency: got dv=%b want 0 at edge k+4", dataValid);
      end
      serialInput = 1'b0;
      tick();
      model_frame(4'b1111, 1'b0, 1'b0);
      n_cmp++;
      if ({out, dataValid, frameError} !== {4'b1111, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL ones: got out=%b dv=%b fe=%b want 1111 1 0",
                  out, dataValid, frameError);
      end
      pulse_ack();
   endtask

   task automatic test_random();
      logic [3:0] d;
      logic       sb;
      logic       ak;
      for (int n = 0; n < 60; n++) begin
         d  = 4'($urandom_range(0, 15));
         sb = ($urandom_range(0, 5) == 0);
         ak = 1'($urandom_range(0, 1));
         drive_frame(d, sb, ak);
         n_cmp++;
         if ({out, notout, dataValid, frameError, overrun} !==
             {m_out, ~m_out, m_dv, m_fe, m_ov}) begin
            n_bad++;
            $display("FAIL random#%0d d=%b sb=%b ack=%b: got %b %b %b %b %b want %b %b %b %b %b",
                     n, d, sb, ak, out, notout, dataValid, frameError, overrun,
                     m_out, ~m_out, m_dv, m_fe, m_ov);
         end
         if ($urandom_range(0, 2) == 0) begin
            pulse_ack();
            n_cmp++;
            if ({dataValid, frameError, overrun, out} !== {m_dv, m_fe, m_ov, m_out}) begin
               n_bad++;
               $display("FAIL random_ack#%0d: got dv=%b fe=%b ov=%b out=%b want %b %b %b %b",
                        n, dataValid, frameError, overrun, out,
                        m_dv, m_fe, m_ov, m_out);
            end
         end
      end
   endtask

   initial begin
      notclear    = 1'b0;
      serialInput = 1'b0;
      acknowledge = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_overrun();
      test_frame_error();
      test_ack_at_stop();
      test_reset_mid();
      test_data_ones();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
